// File: rtl/lift_request_scheduler.sv
// Three-floor lift call scheduler: latches hall/cabin calls, picks the next target by
// sweep direction, hands it to the lift controller and watches for stalled trips.
module lift_request_scheduler #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] hall_call,
  input  logic [2:0] car_call,
  input  logic [2:0] current_floor,
  input  logic       complete_i,
  output logic [2:0] request_floor,
  output logic       request_valid,
  output logic [2:0] pending,
  output logic       served,
  output logic       direction,
  output logic       stall_alert,
  output logic       floor_fault
);

  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      pending_q, pending_d;
  logic [2:0]      target_q, target_d;
  logic            dir_q, dir_d;
  logic            served_q, served_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic [2:0] clear_mask;
  logic [2:0] cand, cand_up, cand_dn;
  logic [2:0] floors_above, floors_below;

  function automatic logic [2:0] lowest_bit(input logic [2:0] v);
    casez (v)
      3'b??1:  return 3'b001;
      3'b?10:  return 3'b010;
      3'b100:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] highest_bit(input logic [2:0] v);
    casez (v)
      3'b1??:  return 3'b100;
      3'b01?:  return 3'b010;
      3'b001:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  assign floor_fault = !((current_floor == 3'b001) || (current_floor == 3'b010) ||
                         (current_floor == 3'b100));

  // Masks of the floors strictly above / below the (one-hot) cabin position.
  assign floors_above = {current_floor[1] | current_floor[0], current_floor[0], 1'b0};
  assign floors_below = {1'b0, current_floor[2], current_floor[2] | current_floor[1]};
  assign cand    = pending_q & ~current_floor;
  assign cand_up = cand & floors_above;
  assign cand_dn = cand & floors_below;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values computed by the combinational processes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      target_q  <= '0;
      dir_q     <= 1'b1;
      served_q  <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      dir_q     <= dir_d;
      served_q  <= served_d;
      timer_q   <= timer_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    dir_d      = dir_q;
    served_d   = 1'b0;
    timer_d    = timer_q;
    clear_mask = '0;

    unique case (state_q)
      S_IDLE: begin
        if (!floor_fault) begin
          if (|(pending_q & current_floor)) begin
            clear_mask = pending_q & current_floor;
            served_d   = 1'b1;
          end else if (|cand) begin
            state_d = S_WAIT;
            timer_d = '0;
            if (dir_q) begin
              if (|cand_up) begin
                target_d = lowest_bit(cand_up);
              end else begin
                target_d = highest_bit(cand_dn);
                dir_d    = 1'b0;
              end
            end else begin
              if (|cand_dn) begin
                target_d = highest_bit(cand_dn);
              end else begin
                target_d = lowest_bit(cand_up);
                dir_d    = 1'b1;
              end
            end
          end
        end
      end
      S_WAIT: begin
        if (complete_i && (current_floor == target_q)) begin
          clear_mask = target_q;
          served_d   = 1'b1;
          state_d    = S_IDLE;
          timer_d    = '0;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Clear beats a same-cycle set on the same bit.
    pending_d = (pending_q | hall_call | car_call) & ~clear_mask;
  end

  always_comb begin
    request_valid = (state_q == S_WAIT);
    request_floor = request_valid ? target_q : 3'b000;
    stall_alert   = (state_q == S_WAIT) && (timer_q >= TW'(TIMEOUT));
    pending       = pending_q;
    served        = served_q;
    direction     = dir_q;
  end

endmodule

// File: doc/lift_request_scheduler.md
LIFT_REQUEST_SCHEDULER -- requirements
Module: lift_request_scheduler

Interface
REQ-001 SHALL take parameter TIMEOUT, default 64, giving the number of WAIT cycles without completion before the stall alert.
REQ-002 SHALL have one clock and synchronous, active-high reset: clk_i  input  1  clock, all state changes on rising edge.
REQ-003 SHALL have rst_i  input  1  synchronous active-high reset.
REQ-004 SHALL have hall_call  input  3  floor-panel call buttons; bit0=floor1 (ground), bit1=floor2, bit2=floor3; any combination is legal.
REQ-005 SHALL have car_call  input  3  cabin buttons, same bit map as hall_call.
REQ-006 SHALL have current_floor  input  3  one-hot cabin position, fed from the lift controller out_current_floor.
REQ-007 SHALL have complete_i  input  1  lift controller arrival indication.
REQ-008 SHALL have request_floor  output  3  one-hot target to the lift controller; 3'b000 when no request is valid.
REQ-009 SHALL have request_valid  output  1  request_floor holds a live target.
REQ-010 SHALL have pending  output  3  latched outstanding calls.
REQ-011 SHALL have served  output  1  one-cycle pulse when a call is cleared.
REQ-012 SHALL have direction  output  1  scheduler sweep direction; 1=up, 0=down.
REQ-013 SHALL have stall_alert  output  1  target not reached within TIMEOUT cycles.
REQ-014 SHALL have floor_fault  output  1  current_floor is not one-hot.

Function
REQ-015 SHALL latch calls: pending <= (pending | hall_call | car_call) & ~clear_mask every cycle; clear wins over a same-cycle set on the same bit.
REQ-016 SHALL implement FSM states IDLE and WAIT only.
REQ-017 SHALL in IDLE, when a pending bit equals current_floor, put that bit in clear_mask, pulse served, and stay in IDLE for that cycle.
REQ-018 SHALL in IDLE select target from cand = pending & ~current_floor. With direction=1: lowest cand floor above current; if none, highest cand below, and set direction=0. With direction=0: the mirror rule.
REQ-019 SHALL on a target selection register the target, drive request_floor=target and request_valid=1 from the next cycle, and enter WAIT; latency from call to request_valid is 2 cycles.
REQ-020 SHALL in WAIT hold request_floor and request_valid stable; calls arriving in WAIT only update pending.
REQ-021 SHALL leave WAIT only on complete_i=1 with current_floor==target: clear the target bit in pending, pulse served, drop request_valid and request_floor to 000 next cycle, clear the timer, and return to IDLE.
REQ-022 SHALL ignore complete_i when current_floor!=target, or when in IDLE.
REQ-023 SHALL hold an 8-bit-minimum wait timer that counts WAIT cycles and saturates; stall_alert is set when the count reaches TIMEOUT and stays set until completion or reset.
REQ-024 SHALL assert floor_fault combinationally while current_floor is not one-hot; IDLE SHALL issue nothing while floor_fault=1, and WAIT is unaffected.
REQ-025 SHALL keep direction unchanged when cand is empty.

Reset
REQ-026 SHALL, on rst_i=1 at a clock edge, force state=IDLE, pending=000, request_floor=000, request_valid=0, served=0, direction=1, stall_alert=0, and timer=0, including mid-WAIT; calls present during reset are discarded.

Verification
REQ-027 current_floor=001, car_call=100 pulse -> pending=100, and request_floor=100 with request_valid=1 two cycles later; complete_i with current_floor=100 -> served pulse, pending=000, request_valid=0.
REQ-028 At floor 010 with direction=1, hall_call=101 in the same cycle -> target 100; after completion, target 001 with direction=0.
REQ-029 In IDLE at floor 001, hall_call=001 -> served pulse next cycle, no request issued.
REQ-030 In WAIT for 100, complete_i withheld for TIMEOUT cycles -> stall_alert=1 and request held; then complete_i -> stall_alert=0.
REQ-031 current_floor=011 with a pending call -> floor_fault=1 and no request issued; a valid current_floor then resumes issue.
REQ-032 rst_i=1 mid-WAIT with pending=110 -> all outputs at reset values next cycle, and rst_i=0 -> idle with no request.
